// File: rtl/alu_op_arbiter.sv
// Round-robin arbiter sharing one ALU between the execute stage (req0) and the AGU (req1).
// Define ALU_ARB_FIXED_PRIO_EN to make req0 always win ties instead of alternating.
module alu_op_arbiter #(
  parameter int          DATA_W       = 16,
  parameter int          MULTI_CYC    = 4,
  parameter logic [15:0] LONG_OP_MASK = 16'hF000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_go,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_ready
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_LONG = 4'(MULTI_CYC - 1);

  state_t            state;
  state_t            state_next;
  logic [3:0]        cnt;
  logic              grant_valid;
  logic              grant_id;
  logic [3:0]        grant_op;
  logic [DATA_W-1:0] grant_a;
  logic [DATA_W-1:0] grant_b;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_id = 1'b0;
    if (!req0_valid && req1_valid) begin
      grant_id = 1'b1;
    end
  end
`else
  logic last_grant;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (state == RESP && rsp_ready) begin
      last_grant <= rsp_id;
    end
  end
`endif

  assign grant_valid = (state == IDLE) && (req0_valid || req1_valid);
  assign grant_op    = grant_id ? req1_op : req0_op;
  assign grant_a     = grant_id ? req1_a  : req0_a;
  assign grant_b     = grant_id ? req1_b  : req0_b;
  assign req0_ready  = grant_valid && !grant_id;
  assign req1_ready  = grant_valid && grant_id;
  assign alu_go      = (state == EXEC);
  assign rsp_valid   = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (grant_valid) state_next = EXEC;
      EXEC: if (cnt == 4'd0) state_next = RESP;
      RESP: if (rsp_ready)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The counter holds the remaining extra EXEC cycles; the result is captured on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      cnt      <= '0;
    end else if (grant_valid) begin
      alu_op <= grant_op;
      alu_a  <= grant_a;
      alu_b  <= grant_b;
      rsp_id <= grant_id;
      cnt    <= LONG_OP_MASK[grant_op] ? CNT_LONG : 4'd0;
    end else if (state == EXEC) begin
      if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end else begin
        rsp_data <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Randomized bench for alu_op_arbiter against a transaction-level timing model.
// Honours ALU_ARB_FIXED_PRIO_EN for the expected tie-break.
module tb_alu_op_arbiter;

  localparam int MC = 4;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op, alu_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [15:0] alu_a, alu_b, alu_result, rsp_data;
  logic        alu_go, rsp_valid, rsp_id, rsp_ready;

  int   vectors;
  int   miscompares;
  int   cyc;
  int   go_seen;
  int   dut_grants[$];

  bit          in_flight;
  int          acc_cyc;
  int          op_len;
  logic        cur_id;
  logic [3:0]  cur_op;
  logic [15:0] cur_a, cur_b;
  logic        last_served;
  logic        gave0, gave1;

  alu_op_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_go(alu_go),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'h0:    return a & b;
      4'h1:    return a | b;
      4'h2:    return a + b;
      4'h3:    return a - b;
      default: return (a ^ b) + {12'h000, op};
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op, alu_a, alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [3:0] op0, input logic [15:0] a0, input logic [15:0] b0,
                               input logic v1, input logic [3:0] op1, input logic [15:0] a1, input logic [15:0] b1,
                               input logic rr);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    rsp_ready  = rr;
  endtask

  // Entered 1 time unit after a rising edge with inputs driven; checks and advances one cycle.
  task automatic runCycle();
    logic e0, e1, win;
    e0 = 1'b0;
    e1 = 1'b0;
    #1;
    if (alu_go) go_seen++;
    if (in_flight && cyc <= acc_cyc + op_len) begin
      checkOutput("alu_go", alu_go, 1);
      checkOutput("alu_op", alu_op, cur_op);
      checkOutput("alu_a", alu_a, cur_a);
      checkOutput("alu_b", alu_b, cur_b);
      checkOutput("rsp_valid_exec", rsp_valid, 0);
    end else if (in_flight) begin
      checkOutput("alu_go_resp", alu_go, 0);
      checkOutput("rsp_valid", rsp_valid, 1);
      checkOutput("rsp_id", rsp_id, cur_id);
      checkOutput("rsp_data", rsp_data, alu_fn(cur_op, cur_a, cur_b));
      if (rsp_ready) begin
        in_flight   = 1'b0;
        last_served = cur_id;
      end
    end else begin
      checkOutput("alu_go_idle", alu_go, 0);
      checkOutput("rsp_valid_idle", rsp_valid, 0);
      if (req0_valid || req1_valid) begin
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
          win = 1'b0;
`else
          win = (last_served == 1'b0) ? 1'b1 : 1'b0;
`endif
        end else begin
          win = req1_valid;
        end
        e0 = !win;
        e1 = win;
        in_flight = 1'b1;
        acc_cyc   = cyc;
        cur_id    = win;
        cur_op    = win ? req1_op : req0_op;
        cur_a     = win ? req1_a : req0_a;
        cur_b     = win ? req1_b : req0_b;
        op_len    = (cur_op >= 4'd12) ? MC : 1;
      end
    end
    checkOutput("req0_ready", req0_ready, e0);
    checkOutput("req1_ready", req1_ready, e1);
    if (req0_ready) dut_grants.push_back(0);
    if (req1_ready) dut_grants.push_back(1);
    gave0 = e0;
    gave1 = e1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idleCycles(input int n, input logic rr);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 4'h0, 16'h0, 16'h0, 0, 4'h0, 16'h0, 16'h0, rr);
      runCycle();
    end
  endtask

  task automatic randomCycles(input int n);
    for (int i = 0; i < n; i++) begin
      if (!req0_valid || gave0 || $urandom_range(0, 7) == 0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_op    = 4'($urandom);
        req0_a     = 16'($urandom);
        req0_b     = 16'($urandom);
      end
      if (!req1_valid || gave1 || $urandom_range(0, 7) == 0) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_op    = 4'($urandom);
        req1_a     = 16'($urandom);
        req1_b     = 16'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      runCycle();
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_alu_op"}, alu_op, 0);
    checkOutput({tag, "_alu_a"}, alu_a, 0);
    checkOutput({tag, "_alu_b"}, alu_b, 0);
    checkOutput({tag, "_alu_go"}, alu_go, 0);
    checkOutput({tag, "_rsp_valid"}, rsp_valid, 0);
    checkOutput({tag, "_rsp_id"}, rsp_id, 0);
    checkOutput({tag, "_rsp_data"}, rsp_data, 0);
  endtask

  task automatic resetModel();
    in_flight   = 1'b0;
    last_served = 1'b1;
    gave0       = 1'b0;
    gave1       = 1'b0;
  endtask

  initial begin
    int exp_order[4];
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    resetModel();
    rst_n = 1'b0;
    applyStimulus(0, 4'h0, 16'h0, 16'h0, 0, 4'h0, 16'h0, 16'h0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst_n = 1'b1;

    // Short op from req0: 5 + 3
    applyStimulus(1, 4'h2, 16'h0005, 16'h0003, 0, 4'h0, 16'h0, 16'h0, 1);
    runCycle();
    go_seen = 0;
    idleCycles(4, 1);
    checkOutput("short_go_len", go_seen, 1);

    // Long op from req1
    applyStimulus(0, 4'h0, 16'h0, 16'h0, 1, 4'hC, 16'h1234, 16'h00FF, 1);
    runCycle();
    go_seen = 0;
    idleCycles(7, 1);
    checkOutput("long_go_len", go_seen, MC);

    // Both requesters continuously valid for four short ops
    dut_grants.delete();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 4'h1, 16'h00F0, 16'h000F, 1, 4'h3, 16'h0100, 16'h0001, 1);
      runCycle();
    end
    idleCycles(3, 1);
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    checkOutput("grant_count", dut_grants.size(), 4);
    for (int i = 0; i < 4 && i < dut_grants.size(); i++) begin
      checkOutput($sformatf("grant_order%0d", i), dut_grants[i], exp_order[i]);
    end

    // Response stalled for 3 cycles while req1 waits
    applyStimulus(1, 4'h5, 16'hAAAA, 16'h5555, 0, 4'h0, 16'h0, 16'h0, 0);
    runCycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 4'h0, 16'h0, 16'h0, 1, 4'h7, 16'h0042, 16'h0011, 0);
      runCycle();
    end
    applyStimulus(0, 4'h0, 16'h0, 16'h0, 1, 4'h7, 16'h0042, 16'h0011, 1);
    runCycle();
    idleCycles(5, 1);

    // Reset in the middle of a long op
    applyStimulus(0, 4'h0, 16'h0, 16'h0, 1, 4'hF, 16'hBEEF, 16'h0101, 1);
    runCycle();
    idleCycles(2, 1);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midexec_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
    resetModel();
    idleCycles(6, 1);
    dut_grants.delete();
    applyStimulus(1, 4'h4, 16'h0033, 16'h0044, 1, 4'h6, 16'h0055, 16'h0066, 1);
    runCycle();
    checkOutput("post_reset_grant_cnt", dut_grants.size(), 1);
    if (dut_grants.size() > 0) checkOutput("post_reset_grant", dut_grants[0], 0);
    idleCycles(3, 1);

    // Every opcode through req0
    for (int op = 0; op < 16; op++) begin
      applyStimulus(1, 4'(op), 16'($urandom), 16'($urandom), 0, 4'h0, 16'h0, 16'h0, 1);
      runCycle();
      go_seen = 0;
      idleCycles(MC + 2, 1);
      checkOutput($sformatf("sweep_len_op%0d", op), go_seen, (op >= 12) ? MC : 1);
    end

    randomCycles(600);
    idleCycles(MC + 4, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
